regfile_fp_param: RTL and testbench
===================================

REGFILE_FP_PARAM -- requirements
Module: regfile_fp_param

Interface
REQ-001 SHALL have parameter DATA_W, default 32: width of one architectural FP register.
REQ-002 SHALL have parameter NREGS, default 32: register count; power of two, >= 4.
REQ-003 SHALL have parameter ADDR_W, default log2(NREGS): register-number width.
REQ-004 SHALL have port clk, input, 1: single clock; all state changes on its rising edge.
REQ-005 SHALL have port reset, input, 1: reset, synchronous and active-high.
REQ-006 SHALL have port writeEnable, input, 1: writeback request this cycle.
REQ-007 SHALL have port rd, input, ADDR_W: writeback destination register.
REQ-008 SHALL have port wr_dbl, input, 1: 1 = 64-bit pair write, 0 = single write.
REQ-009 SHALL have port busW, input, 2*DATA_W: write data; upper half = even register, lower half = odd register or single data.
REQ-010 SHALL have ports ra and rb, input, ADDR_W each: read-port A and read-port B register numbers.
REQ-011 SHALL have ports dblA and dblB, input, 1 each: 1 = pair read on that port.
REQ-012 SHALL have ports busA and busB, output, 2*DATA_W each: read data.
REQ-013 SHALL have ports issue_valid (input, 1), issue_rd (input, ADDR_W) and issue_dbl (input, 1): instruction issue reserving a destination.
REQ-014 SHALL have ports busy_a and busy_b, output, 1 each: a register read on that port has a pending write.
REQ-015 SHALL have port misalign_err, output, 1: registered one-cycle pulse flagging an illegal odd-numbered pair request.

Function
REQ-016 Single write SHALL load reg[rd] <= busW lower DATA_W bits at the clock edge.
REQ-017 Pair write with rd even SHALL load reg[rd] <= upper half and reg[rd+1] <= lower half on the same edge.
REQ-018 Pair write with rd odd SHALL write nothing and SHALL set misalign_err high for the following cycle.
REQ-019 Reads SHALL be combinational (zero latency).
REQ-020 Single read SHALL return {DATA_W zeros, reg[r]}.
REQ-021 Pair read SHALL ignore r[0] and return {reg[r&~1], reg[r|1]}.
REQ-022 Same-cycle bypass: when a write targets a register being read, busA/busB SHALL return the incoming busW half for that register (write-first), per half independently.
REQ-023 Scoreboard: the block SHALL hold one busy bit per register.
REQ-024 A valid issue SHALL set busy[issue_rd], or busy for both registers of the pair when issue_dbl=1 and issue_rd is even.
REQ-025 issue_dbl=1 with odd issue_rd SHALL set no bit and SHALL pulse misalign_err.
REQ-026 A legal write SHALL clear the busy bit(s) of each register it writes.
REQ-027 When issue and write hit the same register in one cycle, set SHALL win: the bit ends at 1.
REQ-028 busy_a/busy_b SHALL be the OR of the busy bits of the register(s) the port reads, excluding any register written in the same cycle (bypass covers it).
REQ-029 Writes to all registers, including register 0, SHALL be legal; there is no hardwired zero register.

Reset
REQ-030 While reset=1 at a clock edge, all registers, all busy bits and misalign_err SHALL become 0.
REQ-031 Reset SHALL take priority over a simultaneous write or issue, which SHALL be discarded.
REQ-032 Combinational outputs SHALL reflect the cleared state in the first cycle after reset; busW bypass still applies in that cycle.

Structure
REQ-033 Package fp_rf_pkg SHALL hold the DATA_W and NREGS defaults, the ADDR_W derivation, and the pair-index helper (r&~1, r|1).
REQ-034 Scoreboard logic (REQ-023 to REQ-028) SHALL be the sub-module fp_scoreboard; storage, bypass and read muxing SHALL stay in the top level.

Verification
REQ-035 Reset, then read ra=5 (single) and rb=6 (pair): busA=0 and busB=0; busy_a=0 and busy_b=0.
REQ-036 Single write rd=3, busW lower=0x3F800000, then read ra=3 next cycle: busA={0,0x3F800000}. In the write cycle itself, busA shows the same value via bypass.
REQ-037 Pair write rd=4, busW=0x400921FB_54442D18, then pair-read rb=5: busB=0x400921FB54442D18. Single read ra=5: busA lower=0x54442D18.
REQ-038 Pair write rd=7: regs 6 and 7 unchanged; misalign_err=1 for exactly one cycle.
REQ-039 Issue rd=8 with issue_dbl=1, then read ra=9: busy_a=1. Write rd=8 as a pair: busy_a=0 in the write cycle and after. Issue rd=8 and write rd=8 in the same cycle: busy_a=1 on the next cycle.
REQ-040 Assert reset in the same cycle as a write to rd=2 and an issue of rd=2: reg2=0 and busy[2]=0 afterwards.

Source files
------------

// File: rtl/fp_rf_pkg.sv
// Shared defaults and helpers for the FP register file.
//   DATA_W_DEF / NREGS_DEF : default register width and register count
//   addr_w_of()            : register-number width for a given count
//   pair_even/pair_odd()   : the two registers of the pair holding r
package fp_rf_pkg;

    localparam int unsigned DATA_W_DEF = 32;
    localparam int unsigned NREGS_DEF  = 32;

    function automatic int unsigned addr_w_of(input int unsigned nregs);
        return $clog2(nregs);
    endfunction

    function automatic int unsigned pair_even(input int unsigned r);
        return r & ~32'd1;
    endfunction

    function automatic int unsigned pair_odd(input int unsigned r);
        return r | 32'd1;
    endfunction

endpackage

// File: rtl/fp_scoreboard.sv
// Busy-bit scoreboard: one pending-write bit per register.
//   clk, reset                  : clock, synchronous active-high reset
//   issue_valid/issue_rd/dbl    : reserve destination register(s)
//   wr_mask                     : registers written this cycle (clears busy)
//   ra/dblA, rb/dblB            : read-port register numbers and pair flags
//   busy_a_c, busy_b_c          : read port hits a pending write (combinational)
//   issue_misalign_c            : odd-numbered pair issue this cycle
module fp_scoreboard
    import fp_rf_pkg::*;
#(
    parameter int unsigned NREGS  = NREGS_DEF,
    parameter int unsigned ADDR_W = addr_w_of(NREGS)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              issue_valid,
    input  logic [ADDR_W-1:0] issue_rd,
    input  logic              issue_dbl,
    input  logic [NREGS-1:0]  wr_mask,
    input  logic [ADDR_W-1:0] ra,
    input  logic              dblA,
    input  logic [ADDR_W-1:0] rb,
    input  logic              dblB,
    output logic              busy_a_c,
    output logic              busy_b_c,
    output logic              issue_misalign_c
);

    logic [NREGS-1:0]  busy;
    logic [NREGS-1:0]  set_mask;
    logic [NREGS-1:0]  live;
    logic [ADDR_W-1:0] issue_odd;
    logic [ADDR_W-1:0] a_even, a_odd, b_even, b_odd;

    assign issue_odd = ADDR_W'(pair_odd(32'(issue_rd)));
    assign a_even    = ADDR_W'(pair_even(32'(ra)));
    assign a_odd     = ADDR_W'(pair_odd(32'(ra)));
    assign b_even    = ADDR_W'(pair_even(32'(rb)));
    assign b_odd     = ADDR_W'(pair_odd(32'(rb)));

    // Issue decode: a pair reservation needs an even base register
    always_comb begin
        set_mask         = '0;
        issue_misalign_c = 1'b0;
        if (issue_valid) begin
            if (!issue_dbl) begin
                set_mask[issue_rd] = 1'b1;
            end else if (!issue_rd[0]) begin
                set_mask[issue_rd]  = 1'b1;
                set_mask[issue_odd] = 1'b1;
            end else begin
                issue_misalign_c = 1'b1;
            end
        end
    end

    // Clear on writeback, then set on issue so a same-cycle issue wins
    always_ff @(posedge clk) begin
        if (reset) begin
            busy <= '0;
        end else begin
            busy <= (busy & ~wr_mask) | set_mask;
        end
    end

    // Registers written this cycle are covered by the bypass path
    assign live = busy & ~wr_mask;

    assign busy_a_c = dblA ? (live[a_even] | live[a_odd]) : live[ra];
    assign busy_b_c = dblB ? (live[b_even] | live[b_odd]) : live[rb];

endmodule

// File: rtl/regfile_fp_param.sv
// FP register file with single/pair access, write-first bypass and
// a busy-bit scoreboard.
//   clk, reset                   : clock, synchronous active-high reset
//   writeEnable, rd, wr_dbl, busW: writeback (upper half = even register)
//   ra/dblA, rb/dblB             : read ports (pair reads ignore r[0])
//   busA, busB                   : combinational read data
//   issue_valid/issue_rd/dbl     : destination reservation
//   busy_a, busy_b               : read port hits a pending write
//   misalign_err                 : one-cycle pulse for odd pair write/issue
module regfile_fp_param
    import fp_rf_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned NREGS  = NREGS_DEF,
    parameter int unsigned ADDR_W = addr_w_of(NREGS)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                writeEnable,
    input  logic [ADDR_W-1:0]   rd,
    input  logic                wr_dbl,
    input  logic [2*DATA_W-1:0] busW,
    input  logic [ADDR_W-1:0]   ra,
    input  logic [ADDR_W-1:0]   rb,
    input  logic                dblA,
    input  logic                dblB,
    output logic [2*DATA_W-1:0] busA,
    output logic [2*DATA_W-1:0] busB,
    input  logic                issue_valid,
    input  logic [ADDR_W-1:0]   issue_rd,
    input  logic                issue_dbl,
    output logic                busy_a,
    output logic                busy_b,
    output logic                misalign_err
);

    logic [DATA_W-1:0] regs    [NREGS];
    logic [DATA_W-1:0] wr_data [NREGS];
    logic [DATA_W-1:0] fwd     [NREGS];
    logic [NREGS-1:0]  wr_mask;
    logic [DATA_W-1:0] hi_w, lo_w;
    logic [ADDR_W-1:0] rd_odd;
    logic [ADDR_W-1:0] a_even, a_odd, b_even, b_odd;
    logic              wr_misalign_c;
    logic              issue_misalign_c;

    assign hi_w   = busW[2*DATA_W-1:DATA_W];
    assign lo_w   = busW[DATA_W-1:0];
    assign rd_odd = ADDR_W'(pair_odd(32'(rd)));
    assign a_even = ADDR_W'(pair_even(32'(ra)));
    assign a_odd  = ADDR_W'(pair_odd(32'(ra)));
    assign b_even = ADDR_W'(pair_even(32'(rb)));
    assign b_odd  = ADDR_W'(pair_odd(32'(rb)));

    // Write decode: every written register takes the lower half except the
    // even register of a pair, which takes the upper half
    always_comb begin
        wr_mask       = '0;
        wr_misalign_c = 1'b0;
        for (int unsigned i = 0; i < NREGS; i++) begin
            wr_data[i] = lo_w;
        end
        if (writeEnable) begin
            if (!wr_dbl) begin
                wr_mask[rd] = 1'b1;
            end else if (!rd[0]) begin
                wr_mask[rd]     = 1'b1;
                wr_mask[rd_odd] = 1'b1;
                wr_data[rd]     = hi_w;
            end else begin
                wr_misalign_c = 1'b1;
            end
        end
    end

    // Write-first view of the register array, used by both read ports
    always_comb begin
        for (int unsigned i = 0; i < NREGS; i++) begin
            fwd[i] = wr_mask[i] ? wr_data[i] : regs[i];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
            misalign_err <= 1'b0;
        end else begin
            for (int unsigned i = 0; i < NREGS; i++) begin
                if (wr_mask[i]) begin
                    regs[i] <= wr_data[i];
                end
            end
            misalign_err <= wr_misalign_c | issue_misalign_c;
        end
    end

    assign busA = dblA ? {fwd[a_even], fwd[a_odd]} : {{DATA_W{1'b0}}, fwd[ra]};
    assign busB = dblB ? {fwd[b_even], fwd[b_odd]} : {{DATA_W{1'b0}}, fwd[rb]};

    fp_scoreboard #(
        .NREGS  (NREGS),
        .ADDR_W (ADDR_W)
    ) u_scoreboard (
        .clk              (clk),
        .reset            (reset),
        .issue_valid      (issue_valid),
        .issue_rd         (issue_rd),
        .issue_dbl        (issue_dbl),
        .wr_mask          (wr_mask),
        .ra               (ra),
        .dblA             (dblA),
        .rb               (rb),
        .dblB             (dblB),
        .busy_a_c         (busy_a),
        .busy_b_c         (busy_b),
        .issue_misalign_c (issue_misalign_c)
    );

endmodule

// File: tb/tb_regfile_fp_param.sv
// Self-checking bench for regfile_fp_param: directed scenarios followed by
// randomized traffic compared against a behavioural register/busy model.
module tb_regfile_fp_param;

    logic        clk;
    logic        reset;
    logic        writeEnable;
    logic [4:0]  rd;
    logic        wr_dbl;
    logic [63:0] busW;
    logic [4:0]  ra, rb;
    logic        dblA, dblB;
    logic [63:0] busA, busB;
    logic        issue_valid;
    logic [4:0]  issue_rd;
    logic        issue_dbl;
    logic        busy_a, busy_b;
    logic        misalign_err;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] m_regs [32];
    bit          m_busy [32];
    bit          m_mis;

    regfile_fp_param dut (
        .clk          (clk),
        .reset        (reset),
        .writeEnable  (writeEnable),
        .rd           (rd),
        .wr_dbl       (wr_dbl),
        .busW         (busW),
        .ra           (ra),
        .rb           (rb),
        .dblA         (dblA),
        .dblB         (dblB),
        .busA         (busA),
        .busB         (busB),
        .issue_valid  (issue_valid),
        .issue_rd     (issue_rd),
        .issue_dbl    (issue_dbl),
        .busy_a       (busy_a),
        .busy_b       (busy_b),
        .misalign_err (misalign_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Does the current write request land in register i?
    function automatic bit wrote(input int i);
        if (!writeEnable) return 1'b0;
        if (!wr_dbl) return int'(rd) == i;
        if (rd[0]) return 1'b0;
        return (int'(rd) == i) || (int'(rd) + 1 == i);
    endfunction

    // Value seen by a reader of register i this cycle (write-first)
    function automatic logic [31:0] val(input int i);
        if (!wrote(i)) return m_regs[i];
        if (wr_dbl && int'(rd) == i) return busW[63:32];
        return busW[31:0];
    endfunction

    function automatic logic [63:0] exp_bus(input logic [4:0] r, input logic d);
        int e;
        e = int'(r) & ~1;
        if (d) return {val(e), val(e + 1)};
        return {32'h0, val(int'(r))};
    endfunction

    function automatic bit exp_busy(input logic [4:0] r, input logic d);
        int e;
        e = int'(r) & ~1;
        if (d) return (m_busy[e] && !wrote(e)) || (m_busy[e + 1] && !wrote(e + 1));
        return m_busy[int'(r)] && !wrote(int'(r));
    endfunction

    task automatic model_clock();
        if (reset) begin
            for (int i = 0; i < 32; i++) begin
                m_regs[i] = '0;
                m_busy[i] = 1'b0;
            end
            m_mis = 1'b0;
        end else begin
            logic [31:0] nv [32];
            bit          wv [32];
            for (int i = 0; i < 32; i++) begin
                wv[i] = wrote(i);
                nv[i] = val(i);
            end
            for (int i = 0; i < 32; i++) begin
                if (wv[i]) begin
                    m_regs[i] = nv[i];
                    m_busy[i] = 1'b0;
                end
            end
            if (issue_valid) begin
                if (!issue_dbl) begin
                    m_busy[int'(issue_rd)] = 1'b1;
                end else if (!issue_rd[0]) begin
                    m_busy[int'(issue_rd)]     = 1'b1;
                    m_busy[int'(issue_rd) + 1] = 1'b1;
                end
            end
            m_mis = (writeEnable && wr_dbl && rd[0]) || (issue_valid && issue_dbl && issue_rd[0]);
        end
    endtask

    task automatic idle();
        reset = 1'b0; writeEnable = 1'b0; rd = '0; wr_dbl = 1'b0; busW = '0;
        ra = '0; rb = '0; dblA = 1'b0; dblB = 1'b0;
        issue_valid = 1'b0; issue_rd = '0; issue_dbl = 1'b0;
    endtask

    // Inputs are applied at the falling edge; compare, clock, advance model
    task automatic step();
        #1;
        check("busA",   busA, exp_bus(ra, dblA));
        check("busB",   busB, exp_bus(rb, dblB));
        check("busy_a", 64'(busy_a), 64'(exp_busy(ra, dblA)));
        check("busy_b", 64'(busy_b), 64'(exp_busy(rb, dblB)));
        check("misalign_err", 64'(misalign_err), 64'(m_mis));
        @(posedge clk);
        model_clock();
        @(negedge clk);
    endtask

    function automatic logic [4:0] rnd_addr(input bit narrow);
        return narrow ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
    endfunction

    initial begin
        bit narrow;
        for (int i = 0; i < 32; i++) begin
            m_regs[i] = '0;
            m_busy[i] = 1'b0;
        end
        m_mis = 1'b0;
        idle();
        reset = 1'b1;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        idle();

        // Cleared state right after reset
        ra = 5'd5; rb = 5'd6; dblB = 1'b1;
        #1;
        check("rst_busA", busA, 64'h0);
        check("rst_busB", busB, 64'h0);
        check("rst_busy_a", 64'(busy_a), 64'h0);
        check("rst_busy_b", 64'(busy_b), 64'h0);
        step();

        // Single write with bypass, then registered read
        idle();
        writeEnable = 1'b1; rd = 5'd3; busW = 64'hDEADBEEF_3F800000; ra = 5'd3;
        #1;
        check("single_bypass", busA, 64'h0000_0000_3F80_0000);
        step();
        idle(); ra = 5'd3;
        #1;
        check("single_read", busA, 64'h0000_0000_3F80_0000);
        step();

        // Pair write and reads
        idle();
        writeEnable = 1'b1; rd = 5'd4; wr_dbl = 1'b1; busW = 64'h400921FB_54442D18;
        step();
        idle(); rb = 5'd5; dblB = 1'b1; ra = 5'd5;
        #1;
        check("pair_read", busB, 64'h400921FB_54442D18);
        check("pair_lo_single", busA, 64'h0000_0000_5444_2D18);
        step();

        // Misaligned pair write
        idle();
        writeEnable = 1'b1; rd = 5'd7; wr_dbl = 1'b1; busW = 64'h11112222_33334444;
        step();
        idle(); rb = 5'd6; dblB = 1'b1;
        #1;
        check("misalign_pulse", 64'(misalign_err), 64'h1);
        check("misalign_nowrite", busB, 64'h0);
        step();
        idle();
        #1;
        check("misalign_drop", 64'(misalign_err), 64'h0);
        step();

        // Scoreboard set/clear/set-wins
        idle(); issue_valid = 1'b1; issue_rd = 5'd8; issue_dbl = 1'b1;
        step();
        idle(); ra = 5'd9;
        #1;
        check("busy_after_issue", 64'(busy_a), 64'h1);
        step();
        idle(); writeEnable = 1'b1; rd = 5'd8; wr_dbl = 1'b1; busW = 64'hAAAA0001_BBBB0002; ra = 5'd9;
        #1;
        check("busy_write_cycle", 64'(busy_a), 64'h0);
        step();
        idle(); ra = 5'd9;
        #1;
        check("busy_after_write", 64'(busy_a), 64'h0);
        step();
        idle(); issue_valid = 1'b1; issue_rd = 5'd8; issue_dbl = 1'b1;
        writeEnable = 1'b1; rd = 5'd8; wr_dbl = 1'b1; busW = 64'hCCCC0003_DDDD0004; ra = 5'd9;
        step();
        idle(); ra = 5'd9;
        #1;
        check("set_wins", 64'(busy_a), 64'h1);
        step();

        // Reset beats a simultaneous write and issue
        idle(); issue_valid = 1'b1; issue_rd = 5'd2; writeEnable = 1'b1; rd = 5'd2; busW = 64'h0000ABCD;
        step();
        idle(); reset = 1'b1; issue_valid = 1'b1; issue_rd = 5'd2;
        writeEnable = 1'b1; rd = 5'd2; busW = 64'h12345678_9ABCDEF0;
        step();
        idle(); ra = 5'd2;
        #1;
        check("rst_prio_reg", busA, 64'h0);
        check("rst_prio_busy", 64'(busy_a), 64'h0);
        step();

        // Randomized traffic against the model
        for (int n = 0; n < 600; n++) begin
            narrow      = ($urandom_range(0, 1) == 1);
            reset       = ($urandom_range(0, 39) == 0);
            writeEnable = ($urandom_range(0, 1) == 1);
            rd          = rnd_addr(narrow);
            wr_dbl      = ($urandom_range(0, 1) == 1);
            busW        = {$urandom, $urandom};
            ra          = rnd_addr(narrow);
            rb          = rnd_addr(narrow);
            dblA        = ($urandom_range(0, 1) == 1);
            dblB        = ($urandom_range(0, 1) == 1);
            issue_valid = ($urandom_range(0, 1) == 1);
            issue_rd    = rnd_addr(narrow);
            issue_dbl   = ($urandom_range(0, 1) == 1);
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
